// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM states and iteration bound for the M-extension sequencer
package muldiv_pkg;
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;
  localparam logic [4:0] ITER_LAST = 5'd31;
  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
endpackage

// File: rtl/muldiv_addsub.sv
// muldiv_addsub: combinational adder/subtractor shared by multiply and divide steps
module muldiv_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, sub ? ~b : b} + {{W{1'b0}}, sub};
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M multiply/divide controller with pipeline stall
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);
  state_t state, state_n;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q, mcand;
  logic [63:0] acc, acc_iter, acc_neg;
  logic [4:0]  cnt;
  logic        neg;
  logic        is_div, sa, sb, neg_n, div0, ovf, special, cout;
  logic [31:0] abs_a, abs_b, special_res, fix_res, quo, rem;
  logic [32:0] add_a, add_b, sum;
  assign is_div      = op_q[2];
  assign sa          = (op_q == OP_MULH || op_q == OP_MULHSU || op_q == OP_DIV || op_q == OP_REM) && a_q[31];
  assign sb          = (op_q == OP_MULH || op_q == OP_DIV || op_q == OP_REM) && b_q[31];
  assign abs_a       = sa ? ~a_q + 32'd1 : a_q;
  assign abs_b       = sb ? ~b_q + 32'd1 : b_q;
  assign neg_n       = (op_q == OP_MULHSU || op_q == OP_REM) ? sa : sa ^ sb;
  assign div0        = is_div && b_q == 32'd0;
  assign ovf         = (op_q == OP_DIV || op_q == OP_REM) && a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF;
  assign special     = div0 || ovf;
  assign special_res = div0 ? (op_q[1] ? a_q : 32'hFFFF_FFFF) : (op_q[1] ? 32'd0 : 32'h8000_0000);
  assign add_a       = is_div ? acc[63:31] : {1'b0, acc[63:32]};
  assign add_b       = {1'b0, mcand};
  muldiv_addsub #(.W(33)) u_addsub (
    .a   (add_a),
    .b   (add_b),
    .sub (is_div),
    .sum (sum),
    .cout(cout)
  );
  assign acc_iter = is_div ? (cout ? {sum[31:0], acc[30:0], 1'b1} : {acc[62:0], 1'b0})
                           : (acc[0] ? {sum, acc[31:1]} : {1'b0, acc[63:1]});
  assign acc_neg  = ~acc + 64'd1;
  assign quo      = acc[31:0];
  assign rem      = acc[63:32];
  assign fix_res  = op_q == OP_MUL ? acc[31:0]
                  : !is_div        ? (neg ? acc_neg[63:32] : acc[63:32])
                  : op_q[1]        ? (neg ? ~rem + 32'd1 : rem)
                  :                  (neg ? ~quo + 32'd1 : quo);
  assign busy  = state != IDLE;
  assign done  = state == DONE;
  assign stall = busy | start;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state; flush aborts any active operation
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (start && !flush) ? PREP : IDLE;
      PREP:    state_n = special ? DONE : ITER;
      ITER:    state_n = cnt == ITER_LAST ? FIX : ITER;
      FIX:     state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush && state != IDLE) state_n = IDLE;
  end
  // operand capture, iteration datapath and result register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      mcand  <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      result <= '0;
    end else begin
      if (state == IDLE && start && !flush) begin
        op_q <= op;
        a_q  <= rs1;
        b_q  <= rs2;
      end
      if (state == PREP) begin
        acc   <= {32'd0, abs_a};
        mcand <= abs_b;
        neg   <= neg_n;
        cnt   <= '0;
        if (special && !flush) result <= special_res;
      end
      if (state == ITER) begin
        acc <= acc_iter;
        cnt <= cnt + 5'd1;
      end
      if (state == FIX && !flush) result <= fix_res;
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: randomized check of the sequencer against an arithmetic reference model
module tb_muldiv_sequencer;
  logic        clk = 1'b0;
  logic        rst, start, flush, busy, stall, done;
  logic [2:0]  op;
  logic [31:0] rs1, rs2, result;
  int compared = 0, mismatched = 0;
  int          m_left = 0, m_age = 0, m_pin_lat = 0, pin_lat = 0;
  logic [31:0] m_res = 0, m_pend = 0, m_pin_val = 0, pin_val = 0;
  logic        m_pin_en = 1'b0, pin_en = 1'b0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .flush(flush), .busy(busy), .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_calc(logic [2:0] o, logic [31:0] a, logic [31:0] b);
    longint sa = {{32{a[31]}}, a};
    longint sb = {{32{b[31]}}, b};
    longint ua = {32'd0, a};
    longint ub = {32'd0, b};
    int ia = a;
    int ib = b;
    logic [63:0] p;
    logic ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    case (o)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return b == 0 ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
      3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
      3'd6: return b == 0 ? a : ovf ? 32'd0 : 32'(ia % ib);
      default: return b == 0 ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(logic [2:0] o, logic [31:0] a, logic [31:0] b);
    return (o[2] && (b == 0 || ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 2 : 35;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: remaining busy cycles, pending and visible result
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_left <= 0;
      m_res  <= 0;
      m_age  <= 0;
    end else if (m_left == 0) begin
      if (start && !flush) begin
        m_left    <= lat_of(op, rs1, rs2);
        m_pend    <= ref_calc(op, rs1, rs2);
        m_age     <= 1;
        m_pin_en  <= pin_en;
        m_pin_val <= pin_val;
        m_pin_lat <= pin_lat;
      end
    end else if (flush) m_left <= 0;
    else begin
      m_left <= m_left - 1;
      m_age  <= m_age + 1;
      if (m_left == 2) m_res <= m_pend;
    end

  // compare DUT outputs with the model every cycle, plus literal pins on directed ops
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_left != 0));
    chk("done", 32'(done), 32'(m_left == 1));
    chk("stall", 32'(stall), 32'((m_left != 0) | start));
    chk("result", result, m_res);
    if (m_left == 1 && m_pin_en) begin
      chk("pin_result", result, m_pin_val);
      chk("pin_latency", 32'(m_age), 32'(m_pin_lat));
    end
  end

  task automatic go(logic [2:0] o, logic [31:0] a, logic [31:0] b, logic [31:0] exp, int lat);
    @(posedge clk); #1;
    start = 1; op = o; rs1 = a; rs2 = b; pin_en = 1; pin_val = exp; pin_lat = lat;
    @(posedge clk); #1;
    start = 0; pin_en = 0;
    repeat (lat) @(posedge clk);
  endtask

  initial begin
    rst = 1; start = 0; flush = 0; op = 0; rs1 = 0; rs2 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    go(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35);
    go(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35);
    go(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35);
    go(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 35);
    go(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);
    go(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35);
    go(3'd5, 32'd1234, 32'd0, 32'hFFFF_FFFF, 2);
    go(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    go(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);
    go(3'd7, 32'h1234, 32'd0, 32'h1234, 2);
    go(3'd5, 32'd100, 32'd7, 32'd14, 35);
    go(3'd7, 32'd100, 32'd7, 32'd2, 35);
    @(posedge clk); #1;
    start = 1; op = 3'd0; rs1 = 32'd5; rs2 = 32'd6;
    @(posedge clk); #1;
    start = 0;
    repeat (11) @(posedge clk);
    #1 flush = 1;
    @(posedge clk); #1;
    flush = 0;
    go(3'd5, 32'd50, 32'd5, 32'd10, 35);
    @(posedge clk); #1;
    start = 1; op = 3'd3; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF;
    repeat (40) @(posedge clk);
    #2 rst = 1;
    @(posedge clk); #1;
    rst = 0; start = 0;
    repeat (8000) begin
      @(posedge clk); #1;
      start = $urandom_range(0, 3) == 0;
      flush = $urandom_range(0, 149) == 0;
      op = 3'($urandom_range(0, 7));
      rs1 = pick();
      rs2 = pick();
    end
    start = 0; flush = 0;
    repeat (40) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
